alu_exec_ctrl: RTL
==================

# alu_exec_ctrl

Parametrised successor to the combinational ALU-control decoder in the EX stage. It fuses opcode/funct decode with a registered, handshaked ALU datapath of configurable width. It adds an iterative multi-cycle multiplier and an illegal-op flag. It sits between the ID/EX pipeline register and EX/MEM, and back-pressures the pipeline through `in_ready` while a MUL is in flight.

## Interface
- `WIDTH`, 32: datapath width; must be ≥ 8 and a power of 2.
- `MUL_BPC`, 1: multiplier bits retired per cycle; must divide `WIDTH`. `MUL_CYC` = `WIDTH`/`MUL_BPC`.
- `SHW`, $clog2(`WIDTH`): derived shift-amount width; not to be overridden.

Ports:
- `Clk` in 1: the single clock; all state changes on its rising edge.
- `Reset` in 1: synchronous, active-high reset.
- `in_valid` in 1: operation presented.
- `in_ready` out 1: block accepts the operation this cycle.
- `ALUOp` in 2: `00` R-type, `01` I-type, `10` forced SUB, `11` illegal.
- `funct` in 6: R-type function field.
- `I_op` in 6: opcode field for I/J-type.
- `A`, `B` in `WIDTH`: operands (rs, rt/immediate).
- `shamt` in `SHW`: shift amount.
- `out_valid` out 1: result held and valid.
- `out_ready` in 1: downstream consumes the result.
- `result` out `WIDTH`: ALU result.
- `zero` out 1: `result` == 0.
- `illegal` out 1: the accepted op did not decode.

## Operation
- Acceptance: `in_valid && in_ready` at an edge.
- `in_ready` = (state == IDLE) && (!`out_valid` || `out_ready`).
- Decode when `ALUOp`=00, by `funct`:
  - 100000 ADD; 100010 SUB; 011000 MUL.
  - 100100 AND; 100101 OR; 100111 NOR; 100110 XOR.
  - 000000 SLL (B<<shamt); 000010 SRL (B>>shamt, logical).
  - 101010 SLT (signed A<B → 1, else 0).
- Decode when `ALUOp`=01, by `I_op`:
  - ADD: 101011, 100011, 101000, 100000, 101001, 100001, 001000.
  - 001100 AND; 001101 OR; 001110 XOR; 001010 SLT.
  - SUB: 000001, 000100, 000101, 000111, 000110.
  - PASSA (`result`=A): 000010, 000011.
- `ALUOp`=10 → SUB.
- Any other combination → `illegal`=1, `result`=0, single-cycle path.
- Arithmetic wraps modulo 2^`WIDTH`. No overflow trap.
- MUL returns the low `WIDTH` bits of A×B. These are identical for signed and unsigned operands.
- FSM states IDLE, MUL, HOLD:
  - IDLE: on accepting a non-MUL op, register `result`, `zero`, `illegal`, set `out_valid`; stay in IDLE. On accepting MUL, latch A/B, clear the accumulator and iteration counter, go to MUL.
  - MUL: each cycle, add (multiplicand × low `MUL_BPC` multiplier bits) to the accumulator. Shift the multiplicand left and the multiplier right by `MUL_BPC`, and increment the counter. On the count reaching `MUL_CYC`, load `result`, set `out_valid`, go to HOLD.
  - HOLD: go to IDLE unconditionally on the next edge. `out_valid` stays until consumed.
- `out_valid` clears on an edge with `out_ready`=1, unless a new op is accepted on the same edge. In that case the new single-cycle result replaces the old one and `out_valid` stays 1.
- `result`, `zero`, `illegal` are stable while `out_valid`=1 && `out_ready`=0.

## Timing
- Reset values: state IDLE, `out_valid`=0, `result`=0, `zero`=0, `illegal`=0, counter 0. `in_ready`=1 in the first cycle after reset.
- Single-cycle ops: accepted at edge N, `out_valid` from edge N.
- Throughput: 1 op/cycle while `out_ready`=1.
- MUL: accepted at edge N, `out_valid` at edge N+`MUL_CYC`. `in_ready`=0 from edge N until the edge after `out_valid` rises (HOLD→IDLE).
- `in_ready` depends combinationally on `out_ready`. No other combinational input→output paths.
- `Reset` mid-MUL or while holding a result aborts the op. All outputs take reset values at that edge. A result pending during reset is discarded.
- Inputs are ignored while `in_ready`=0, even if `in_valid`=1.
- Backpressure during MUL: the multiply completes, then waits in the output register for `out_ready`.

## Test plan
- Reset, then ADD A=0x7FFFFFFF, B=1 → next edge `out_valid`=1, `result`=0x80000000, `zero`=0. Follow with SUB 5−5 (ALUOp=10) → `result`=0, `zero`=1.
- Back-to-back with `out_ready`=1: AND 0xF0F0&0xFF00, NOR 0/0, SLL B=1 shamt=31, SLT A=−1 B=0 → results 0xF000, 0xFFFFFFFF, 0x80000000, 1 on consecutive cycles, `in_ready` stuck high.
- MUL 0xFFFFFFFF×3 with `MUL_BPC`=1 → `in_ready` low, result 0xFFFFFFFD exactly 32 cycles after acceptance. Repeat with `MUL_BPC`=4 → 8 cycles.
- Hold `out_ready`=0 for 5 cycles after an XORI (I_op=001110, 0xFF^0x0F) → `result`=0xF0 held stable, `in_ready`=0. Release → consumed in one cycle.
- ALUOp=00 funct=111111 and ALUOp=11 → `illegal`=1, `result`=0, `zero`=1. A following ADD clears `illegal`.
- Assert `Reset` at MUL cycle 10 → next edge `out_valid`=0, `result`=0, `in_ready`=1. A new ADD 2+2 then returns 4.

Source files
------------

// File: rtl/alu_exec_ctrl.sv
// rtl/alu_exec_ctrl.sv - EX-stage ALU with fused op decode, handshaked result register and iterative multiplier
module alu_exec_ctrl #(
   parameter int WIDTH   = 32,
   parameter int MUL_BPC = 1,
   parameter int SHW     = $clog2(WIDTH)
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       ALUOp,
   input  logic [5:0]       funct,
   input  logic [5:0]       I_op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [SHW-1:0]   shamt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             illegal
);

   localparam int MUL_CYC = WIDTH / MUL_BPC;
   localparam int CNT_W   = $clog2(MUL_CYC) + 1;

   typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_HOLD} state_e;

   typedef enum logic [3:0] {
      OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_NOR, OP_XOR,
      OP_SLL, OP_SRL, OP_SLT, OP_PASSA, OP_ILL
   } op_e;

   state_e             r_state;
   state_e             w_next;
   op_e                w_op;
   logic [WIDTH-1:0]   w_alu;
   logic [WIDTH-1:0]   w_partial;
   logic [WIDTH-1:0]   w_acc_next;
   logic               w_accept;
   logic               w_is_mul;
   logic               w_mul_last;
   logic [WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [WIDTH-1:0]   r_acc;
   logic [CNT_W-1:0]   r_cnt;

   assign in_ready   = (r_state == ST_IDLE) && (!out_valid || out_ready);
   assign w_accept   = in_valid && in_ready;
   assign w_is_mul   = (w_op == OP_MUL);
   assign w_mul_last = (r_cnt == CNT_W'(MUL_CYC - 1));

   always_comb begin
      w_op = OP_ILL;
      case (ALUOp)
         2'b00: begin
            case (funct)
               6'b100000: w_op = OP_ADD;
               6'b100010: w_op = OP_SUB;
               6'b011000: w_op = OP_MUL;
               6'b100100: w_op = OP_AND;
               6'b100101: w_op = OP_OR;
               6'b100111: w_op = OP_NOR;
               6'b100110: w_op = OP_XOR;
               6'b000000: w_op = OP_SLL;
               6'b000010: w_op = OP_SRL;
               6'b101010: w_op = OP_SLT;
               default:   w_op = OP_ILL;
            endcase
         end
         2'b01: begin
            case (I_op)
               6'b101011, 6'b100011, 6'b101000, 6'b100000,
               6'b101001, 6'b100001, 6'b001000: w_op = OP_ADD;
               6'b001100: w_op = OP_AND;
               6'b001101: w_op = OP_OR;
               6'b001110: w_op = OP_XOR;
               6'b001010: w_op = OP_SLT;
               6'b000001, 6'b000100, 6'b000101,
               6'b000111, 6'b000110: w_op = OP_SUB;
               6'b000010, 6'b000011: w_op = OP_PASSA;
               default:   w_op = OP_ILL;
            endcase
         end
         2'b10:   w_op = OP_SUB;
         default: w_op = OP_ILL;
      endcase
   end

   always_comb begin
      w_alu = '0;
      case (w_op)
         OP_ADD:   w_alu = A + B;
         OP_SUB:   w_alu = A - B;
         OP_AND:   w_alu = A & B;
         OP_OR:    w_alu = A | B;
         OP_NOR:   w_alu = ~(A | B);
         OP_XOR:   w_alu = A ^ B;
         OP_SLL:   w_alu = B << shamt;
         OP_SRL:   w_alu = B >> shamt;
         OP_SLT:   w_alu = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
         OP_PASSA: w_alu = A;
         default:  w_alu = '0;
      endcase
   end

   // Shift-and-add partial product for the low MUL_BPC multiplier bits
   always_comb begin
      w_partial = '0;
      for (int i = 0; i < MUL_BPC; i++) begin
         if (r_mplier[i]) begin
            w_partial = w_partial + (r_mcand << i);
         end
      end
   end

   assign w_acc_next = r_acc + w_partial;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (w_accept && w_is_mul) w_next = ST_MUL;
         ST_MUL:  if (w_mul_last) w_next = ST_HOLD;
         ST_HOLD: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         out_valid <= 1'b0;
         result    <= '0;
         zero      <= 1'b0;
         illegal   <= 1'b0;
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
      end else begin
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  if (w_is_mul) begin
                     r_mcand  <= A;
                     r_mplier <= B;
                     r_acc    <= '0;
                     r_cnt    <= '0;
                  end else begin
                     // A new single-cycle op overrides the clear of a consumed result
                     result    <= w_alu;
                     zero      <= (w_alu == '0);
                     illegal   <= (w_op == OP_ILL);
                     out_valid <= 1'b1;
                  end
               end
            end
            ST_MUL: begin
               r_acc    <= w_acc_next;
               r_mcand  <= r_mcand << MUL_BPC;
               r_mplier <= r_mplier >> MUL_BPC;
               r_cnt    <= r_cnt + 1'b1;
               if (w_mul_last) begin
                  result    <= w_acc_next;
                  zero      <= (w_acc_next == '0);
                  illegal   <= 1'b0;
                  out_valid <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
